// File: rtl/saes32_iter_engine_if.sv
// Request/response bundle between the crypto FU issue logic and the AES round engine.
// master = requester (drives operands, consumes result); slave = engine.
// Ports: req_valid/req_ready handshake with dec/mix/word/bs/rs1/rs2 operands;
//        rsp_valid/rsp_ready handshake with the 32-bit rsp_rd result.
interface saes32_iter_engine_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_dec;
  logic        req_mix;
  logic        req_word;
  logic [1:0]  req_bs;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rd;

  modport master (
    output req_valid, req_dec, req_mix, req_word, req_bs, req_rs1, req_rs2, rsp_ready,
    input  req_ready, rsp_valid, rsp_rd
  );

  modport slave (
    input  req_valid, req_dec, req_mix, req_word, req_bs, req_rs1, req_rs2, rsp_ready,
    output req_ready, rsp_valid, rsp_rd
  );
endinterface

// File: rtl/saes32_iter_engine.sv
// AES round engine: rd = rs1 ^ XOR_i rotl(f(rs2.byte[i]), 8*i), byte or whole-column ops.
// Latency accept->rsp_valid: word 4/SBOXES+1 cycles, byte 2 cycles.
// Result held in DONE until rsp_ready; with ALLOW_B2B a new request is taken as it drains.
// Ports: g_clk, g_resetn (async active-low), flush (sync abort, highest priority),
//        bus (slave side of saes32_iter_engine_if: request operands in, result out).
module saes32_iter_engine #(
  parameter int SBOXES    = 4,
  parameter bit ALLOW_B2B = 1'b1
) (
  input  logic                 g_clk,
  input  logic                 g_resetn,
  input  logic                 flush,
  saes32_iter_engine_if.slave  bus
);

  localparam int         BATCHES  = 4 / SBOXES;
  localparam logic [1:0] LAST_CNT = 2'(BATCHES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state, state_nxt;
  logic [1:0]  cnt, cnt_nxt;
  logic [31:0] acc, acc_nxt;
  logic        load;
  logic        accept;
  logic        req_ready_int;
  logic        batch_last;

  logic        dec_q, mix_q, word_q;
  logic [1:0]  bs_q;
  logic [31:0] rs2_q;

  logic [31:0] lane_term [SBOXES];
  logic [31:0] lane_sum;

  // ---------------------------------------------------------------- GF(2^8)
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, p;
    r = 8'h00;
    p = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ p;
      p = xt(p);
    end
    return r;
  endfunction

  // a^254 == a^-1 in GF(2^8), and maps 0 to 0 as the S-box needs.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r, p;
    r = 8'h01;
    p = a;
    for (int k = 1; k < 8; k++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox_fwd(input logic [7:0] s);
    logic [7:0] b;
    b = gf_inv(s);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] sbox_inv(input logic [7:0] s);
    return gf_inv(rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05);
  endfunction

  // Column contribution of one substituted byte, before positional rotation.
  function automatic logic [31:0] col_fn(input logic [7:0] t, input logic dec, input logic mix);
    logic [7:0] t2, t4, t8;
    t2 = xt(t);
    t4 = xt(t2);
    t8 = xt(t4);
    if (!mix)    return {24'h0, t};
    else if (dec) return {t8 ^ t2 ^ t, t8 ^ t4 ^ t, t8 ^ t, t8 ^ t4 ^ t2};
    else         return {t2 ^ t, t, t, t2};
  endfunction

  function automatic logic [31:0] rot_bytes(input logic [31:0] w, input logic [1:0] n);
    case (n)
      2'd0:    return w;
      2'd1:    return {w[23:0], w[31:24]};
      2'd2:    return {w[15:0], w[31:16]};
      default: return {w[7:0],  w[31:8]};
    endcase
  endfunction

  // ------------------------------------------------------------------ lanes
  // A disabled lane sees a constant zero byte so its S-box does not toggle,
  // and its term is forced to zero so it never disturbs the accumulator.
  for (genvar k = 0; k < SBOXES; k++) begin : g_lane
    localparam bit LANE0 = (k == 0);
    logic        en;
    logic [1:0]  idx;
    logic [7:0]  s_in, t;
    logic [31:0] f;

    assign en   = (state == BUSY) && (word_q || LANE0);
    assign idx  = word_q ? 2'(int'(cnt) * SBOXES + k) : bs_q;
    assign s_in = en ? rs2_q[8*idx +: 8] : 8'h00;
    assign t    = dec_q ? sbox_inv(s_in) : sbox_fwd(s_in);
    assign f    = col_fn(t, dec_q, mix_q);
    assign lane_term[k] = en ? rot_bytes(f, idx) : 32'h0;
  end

  always_comb begin
    lane_sum = 32'h0;
    for (int k = 0; k < SBOXES; k++) lane_sum = lane_sum ^ lane_term[k];
  end

  // -------------------------------------------------------------------- FSM
  // req_ready depends only on state and rsp_ready; flush gates the accept
  // itself rather than req_ready, so there is no path from req_valid.
  assign req_ready_int = (state == IDLE) || (ALLOW_B2B && (state == DONE) && bus.rsp_ready);
  assign accept        = bus.req_valid && req_ready_int && !flush;
  assign batch_last    = !word_q || (cnt == LAST_CNT);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    acc_nxt   = acc;
    load      = 1'b0;
    if (flush) begin
      state_nxt = IDLE;
      cnt_nxt   = 2'd0;
      acc_nxt   = 32'h0;
    end else begin
      case (state)
        IDLE: if (accept) load = 1'b1;
        BUSY: begin
          acc_nxt = acc ^ lane_sum;
          if (batch_last) begin
            state_nxt = DONE;
            cnt_nxt   = 2'd0;
          end else begin
            cnt_nxt   = cnt + 2'd1;
          end
        end
        DONE: begin
          if (bus.rsp_ready) begin
            if (accept) load = 1'b1;
            else        state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
      if (load) begin
        state_nxt = BUSY;
        cnt_nxt   = 2'd0;
        acc_nxt   = bus.req_rs1;
      end
    end
  end

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state <= IDLE;
      cnt   <= 2'd0;
      acc   <= 32'h0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      acc   <= acc_nxt;
    end
  end

  // Operands are captured only at accept; later input changes are ignored.
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      dec_q  <= 1'b0;
      mix_q  <= 1'b0;
      word_q <= 1'b0;
      bs_q   <= 2'd0;
      rs2_q  <= 32'h0;
    end else if (load) begin
      dec_q  <= bus.req_dec;
      mix_q  <= bus.req_mix;
      word_q <= bus.req_word;
      bs_q   <= bus.req_bs;
      rs2_q  <= bus.req_rs2;
    end
  end

  assign bus.req_ready = req_ready_int;
  assign bus.rsp_valid = (state == DONE);
  assign bus.rsp_rd    = acc;

endmodule

// File: tb/tb_saes32_iter_engine.sv
// Directed bench for saes32_iter_engine, run on SBOXES = 1, 2 and 4 instances.
// Vectors carry hand-computed results; latency, back-pressure, back-to-back,
// flush and mid-operation reset are exercised as explicit sequences.
module tb_saes32_iter_engine;

  logic g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  typedef struct {
    logic        dec;
    logic        mix;
    logic        word;
    logic [1:0]  bs;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs [12];

  int n_checks = 0;
  int n_fail   = 0;

  logic        rst_n_a     [3];
  logic        flush_a     [3];
  logic        req_valid_a [3];
  logic        req_dec_a   [3];
  logic        req_mix_a   [3];
  logic        req_word_a  [3];
  logic [1:0]  req_bs_a    [3];
  logic [31:0] req_rs1_a   [3];
  logic [31:0] req_rs2_a   [3];
  logic        rsp_ready_a [3];
  logic        req_ready_a [3];
  logic        rsp_valid_a [3];
  logic [31:0] rsp_rd_a    [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    saes32_iter_engine_if bus ();
    assign bus.req_valid = req_valid_a[g];
    assign bus.req_dec   = req_dec_a[g];
    assign bus.req_mix   = req_mix_a[g];
    assign bus.req_word  = req_word_a[g];
    assign bus.req_bs    = req_bs_a[g];
    assign bus.req_rs1   = req_rs1_a[g];
    assign bus.req_rs2   = req_rs2_a[g];
    assign bus.rsp_ready = rsp_ready_a[g];
    assign req_ready_a[g] = bus.req_ready;
    assign rsp_valid_a[g] = bus.rsp_valid;
    assign rsp_rd_a[g]    = bus.rsp_rd;

    saes32_iter_engine #(.SBOXES(1 << g), .ALLOW_B2B(1'b1)) dut (
      .g_clk    (g_clk),
      .g_resetn (rst_n_a[g]),
      .flush    (flush_a[g]),
      .bus      (bus)
    );
  end

  task automatic check(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (SBOXES=%0d): got 0x%08h, want 0x%08h", name, 1 << inst, act, exp);
    end
  endtask

  // Offer v at the next falling edge, let it be accepted, then scramble the
  // inputs so a design that resamples them during BUSY gives a wrong result.
  task automatic issue(input int inst, input vec_t v);
    @(negedge g_clk);
    req_valid_a[inst] = 1'b1;
    req_dec_a[inst]   = v.dec;
    req_mix_a[inst]   = v.mix;
    req_word_a[inst]  = v.word;
    req_bs_a[inst]    = v.bs;
    req_rs1_a[inst]   = v.rs1;
    req_rs2_a[inst]   = v.rs2;
    #1 check("req_ready_idle", inst, 32'(req_ready_a[inst]), 32'd1);
    @(posedge g_clk);
    @(negedge g_clk);
    req_valid_a[inst] = 1'b0;
    req_dec_a[inst]   = ~v.dec;
    req_mix_a[inst]   = ~v.mix;
    req_word_a[inst]  = ~v.word;
    req_bs_a[inst]    = ~v.bs;
    req_rs1_a[inst]   = ~v.rs1;
    req_rs2_a[inst]   = ~v.rs2;
  endtask

  // Called at the falling edge after the accept edge; lat counts that edge as 1.
  task automatic wait_rsp(input int inst, output int lat);
    lat = 1;
    while (!rsp_valid_a[inst] && lat < 20) begin
      @(negedge g_clk);
      lat++;
    end
  endtask

  task automatic consume(input int inst);
    rsp_ready_a[inst] = 1'b1;
    @(posedge g_clk);
    @(negedge g_clk);
    rsp_ready_a[inst] = 1'b0;
    #1 check("rsp_valid_after_consume", inst, 32'(rsp_valid_a[inst]), 32'd0);
  endtask

  task automatic no_valid_for(input string name, input int inst, input int cycles);
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge g_clk);
      if (rsp_valid_a[inst]) seen = 1'b1;
    end
    check(name, inst, 32'(seen), 32'd0);
  endtask

  function automatic int exp_lat(input int inst, input logic word);
    return word ? (4 / (1 << inst)) + 1 : 2;
  endfunction

  task automatic run_vec(input int inst, input int idx);
    int lat;
    issue(inst, vecs[idx]);
    #1 check($sformatf("req_ready_busy[%0d]", idx), inst, 32'(req_ready_a[inst]), 32'd0);
    wait_rsp(inst, lat);
    check($sformatf("latency[%0d]", idx), inst, 32'(lat), 32'(exp_lat(inst, vecs[idx].word)));
    check($sformatf("rd[%0d]", idx), inst, rsp_rd_a[inst], vecs[idx].rd);
    consume(inst);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int   lat;
    int   nf;
    vec_t v;

    //          dec   mix   word  bs    rs1           rs2           rd
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 2'd0, 32'h00000000, 32'h00000000, 32'h63636363};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 2'd0, 32'h00000000, 32'h00000001, 32'h847C7CF8};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 2'd0, 32'h0000FFFF, 32'h00000000, 32'h63639C9C};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 2'd1, 32'hDEADBEEF, 32'h00006300, 32'hDEADBEEF};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 2'd0, 32'h00000000, 32'hFF105301, 32'h16CAED7C};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 2'd0, 32'h11111111, 32'h16CAED7C, 32'hEE014210};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 2'd3, 32'h00000000, 32'h53AABBCC, 32'hED000000};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 2'd2, 32'hFFFFFFFF, 32'h12FF3456, 32'hFFE9FFFF};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 2'd2, 32'h00000000, 32'h007C0000, 32'h090E0B0D};
    vecs[9]  = '{1'b1, 1'b1, 1'b1, 2'd0, 32'h00000000, 32'h7C7C7C7C, 32'h01010101};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 2'd1, 32'h00000000, 32'h00000200, 32'h7777EE99};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 2'd2, 32'h00000000, 32'h00000001, 32'h427C7C5D};

    for (int i = 0; i < 3; i++) begin
      rst_n_a[i]     = 1'b0;
      flush_a[i]     = 1'b0;
      req_valid_a[i] = 1'b0;
      req_dec_a[i]   = 1'b0;
      req_mix_a[i]   = 1'b0;
      req_word_a[i]  = 1'b0;
      req_bs_a[i]    = 2'd0;
      req_rs1_a[i]   = 32'h0;
      req_rs2_a[i]   = 32'h0;
      rsp_ready_a[i] = 1'b0;
    end

    for (int inst = 0; inst < 3; inst++) begin
      // Reset state.
      @(negedge g_clk);
      check("reset_rsp_valid", inst, 32'(rsp_valid_a[inst]), 32'd0);
      check("reset_rsp_rd", inst, rsp_rd_a[inst], 32'h0);
      rst_n_a[inst] = 1'b1;
      #1 check("reset_req_ready", inst, 32'(req_ready_a[inst]), 32'd1);

      // Directed vectors.
      for (int idx = 0; idx < 12; idx++) run_vec(inst, idx);

      // Back-pressure, then a back-to-back accept in the draining cycle.
      issue(inst, vecs[1]);
      wait_rsp(inst, lat);
      check("bp_first_rd", inst, rsp_rd_a[inst], vecs[1].rd);
      for (int c = 0; c < 3; c++) begin
        @(negedge g_clk);
        check("bp_hold_valid", inst, 32'(rsp_valid_a[inst]), 32'd1);
        check("bp_hold_rd", inst, rsp_rd_a[inst], vecs[1].rd);
        check("bp_hold_req_ready", inst, 32'(req_ready_a[inst]), 32'd0);
      end
      rsp_ready_a[inst] = 1'b1;
      req_valid_a[inst] = 1'b1;
      req_dec_a[inst]   = vecs[2].dec;
      req_mix_a[inst]   = vecs[2].mix;
      req_word_a[inst]  = vecs[2].word;
      req_bs_a[inst]    = vecs[2].bs;
      req_rs1_a[inst]   = vecs[2].rs1;
      req_rs2_a[inst]   = vecs[2].rs2;
      #1 check("b2b_req_ready", inst, 32'(req_ready_a[inst]), 32'd1);
      @(posedge g_clk);
      @(negedge g_clk);
      rsp_ready_a[inst] = 1'b0;
      req_valid_a[inst] = 1'b0;
      req_rs2_a[inst]   = 32'hA5A5A5A5;
      #1 check("b2b_busy_no_valid", inst, 32'(rsp_valid_a[inst]), 32'd0);
      wait_rsp(inst, lat);
      check("b2b_latency", inst, 32'(lat), 32'(exp_lat(inst, 1'b1)));
      check("b2b_rd", inst, rsp_rd_a[inst], vecs[2].rd);
      consume(inst);

      // Flush during BUSY (second BUSY cycle where the op has one).
      v = vecs[0];
      v.rs1 = 32'hFFFFFFFF;
      issue(inst, v);
      nf = ((4 / (1 << inst)) >= 2) ? 2 : 1;
      repeat (nf - 1) @(negedge g_clk);
      flush_a[inst] = 1'b1;
      @(posedge g_clk);
      @(negedge g_clk);
      flush_a[inst] = 1'b0;
      #1 check("flush_rsp_valid", inst, 32'(rsp_valid_a[inst]), 32'd0);
      check("flush_req_ready", inst, 32'(req_ready_a[inst]), 32'd1);
      check("flush_acc_cleared", inst, rsp_rd_a[inst], 32'h0);
      no_valid_for("flush_no_rsp", inst, 8);

      // A request offered together with flush must not be taken.
      @(negedge g_clk);
      flush_a[inst]     = 1'b1;
      req_valid_a[inst] = 1'b1;
      req_word_a[inst]  = 1'b1;
      req_rs1_a[inst]   = 32'h12345678;
      @(posedge g_clk);
      @(negedge g_clk);
      flush_a[inst]     = 1'b0;
      req_valid_a[inst] = 1'b0;
      #1 check("flush_req_not_taken", inst, 32'(req_ready_a[inst]), 32'd1);
      no_valid_for("flush_req_no_rsp", inst, 8);

      // Asynchronous reset while BUSY.
      issue(inst, v);
      rst_n_a[inst] = 1'b0;
      #1 check("arst_rsp_valid", inst, 32'(rsp_valid_a[inst]), 32'd0);
      check("arst_rsp_rd", inst, rsp_rd_a[inst], 32'h0);
      @(negedge g_clk);
      rst_n_a[inst] = 1'b1;
      no_valid_for("arst_no_rsp", inst, 8);
      check("arst_req_ready", inst, 32'(req_ready_a[inst]), 32'd1);

      // Engine still works after the abort.
      run_vec(inst, 11);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
